// File: rtl/guitar_pkg.sv
// guitar_pkg: shared lane count, multiplier rules and judge state type
package guitar_pkg;
    localparam int NUM_LANES = 5;
    localparam int MULT_STEP = 10;
    localparam int MAX_MULT  = 4;
    typedef enum logic [1:0] {IDLE, OPEN, JUDGED} state_t;
    // Multiplier for a given streak: one step per MULT_STEP hits, capped at MAX_MULT.
    function automatic logic [2:0] mult_of(input int unsigned s);
        logic [2:0] m;
        m = 3'd1;
        for (int k = 1; k < MAX_MULT; k++) begin
            if (s >= int'(MULT_STEP * k)) m = 3'(k + 1);
        end
        return m;
    endfunction
endpackage

// File: rtl/note_judge_if.sv
// note_judge_if: note/controller bundle between the judge and the rest of the game
// master: drives beat, notes_to_play, frets, strum, pause; samples correct_notes, hit, miss,
//         score, streak, multiplier.
// slave:  the judge; the opposite directions.
interface note_judge_if #(
    parameter int SCORE_W  = 16,
    parameter int STREAK_W = 8
);
    import guitar_pkg::*;
    logic                 beat;
    logic [NUM_LANES-1:0] notes_to_play;
    logic [NUM_LANES-1:0] frets;
    logic                 strum;
    logic                 pause;
    logic [NUM_LANES-1:0] correct_notes;
    logic                 hit;
    logic                 miss;
    logic [SCORE_W-1:0]   score;
    logic [STREAK_W-1:0]  streak;
    logic [2:0]           multiplier;
    modport master (
        output beat, notes_to_play, frets, strum, pause,
        input  correct_notes, hit, miss, score, streak, multiplier
    );
    modport slave (
        input  beat, notes_to_play, frets, strum, pause,
        output correct_notes, hit, miss, score, streak, multiplier
    );
endinterface

// File: rtl/score_accumulator.sv
// score_accumulator: streak, multiplier and score registers with saturation
// Ports: clk, reset (sync, active high), add_hit (credit one hit), clear_streak (break the streak);
//        score, streak, multiplier (1..4, derived from the post-update streak).
module score_accumulator
    import guitar_pkg::*;
#(
    parameter int SCORE_W         = 16,
    parameter int STREAK_W        = 8,
    parameter int POINTS_PER_NOTE = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                add_hit,
    input  logic                clear_streak,
    output logic [SCORE_W-1:0]  score,
    output logic [STREAK_W-1:0] streak,
    output logic [2:0]          multiplier
);
    localparam int SW = SCORE_W + 8;
    logic [STREAK_W-1:0] streak_inc;
    logic [SW-1:0]       sum;
    assign streak_inc = &streak ? streak : streak + 1'b1;
    // Points use the multiplier in force before this hit; the wide sum exposes overflow.
    assign sum = SW'(score) + SW'(POINTS_PER_NOTE * int'(multiplier));
    always_ff @(posedge clk) begin
        if (reset) begin
            score      <= '0;
            streak     <= '0;
            multiplier <= 3'd1;
        end else if (add_hit) begin
            score      <= |sum[SW-1:SCORE_W] ? '1 : sum[SCORE_W-1:0];
            streak     <= streak_inc;
            multiplier <= mult_of(32'(streak_inc));
        end else if (clear_streak) begin
            streak     <= '0;
            multiplier <= 3'd1;
        end
    end
endmodule

// File: rtl/note_judge.sv
// note_judge: judges strums against the beat-latched note word and keeps score/streak/multiplier
// Ports: clk, reset (sync, active high);
//        bus (note_judge_if.slave): beat, notes_to_play, frets, strum, pause in;
//        correct_notes, hit, miss, score, streak, multiplier out (all registered).
// Optional: NOTE_JUDGE_OVERSTRUM_PENALTY_EN makes strums outside an open window count as misses.
module note_judge
    import guitar_pkg::*;
#(
    parameter int WINDOW_CYCLES   = 2500000,
    parameter int SCORE_W         = 16,
    parameter int STREAK_W        = 8,
    parameter int POINTS_PER_NOTE = 10
) (
    input logic         clk,
    input logic         reset,
    note_judge_if.slave bus
);
    localparam int            CW   = $clog2(WINDOW_CYCLES);
    localparam logic [CW-1:0] LOAD = CW'(WINDOW_CYCLES - 1);
    state_t               state, state_n;
    logic [NUM_LANES-1:0] expected, expected_n, correct_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic                 strum_d, strum_e, hit_n, miss_n;
    assign strum_e = bus.strum & ~strum_d;
    // The open note is judged first; a beat in the same cycle is then handled as from IDLE,
    // so it clears correct_notes and starts the next window.
    always_comb begin
        state_n    = state;
        expected_n = expected;
        cnt_n      = cnt;
        correct_n  = bus.correct_notes;
        hit_n      = 1'b0;
        miss_n     = 1'b0;
        if (!bus.pause) begin
            if (state == OPEN) begin
                if (strum_e) begin
                    hit_n     = bus.frets == expected;
                    miss_n    = bus.frets != expected;
                    correct_n = hit_n ? expected : bus.correct_notes;
                    state_n   = JUDGED;
                end else if (bus.beat || cnt == '0) begin
                    miss_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
`ifdef NOTE_JUDGE_OVERSTRUM_PENALTY_EN
            else begin
                miss_n = strum_e;
            end
`endif
            if (bus.beat) begin
                correct_n  = '0;
                expected_n = bus.notes_to_play;
                cnt_n      = LOAD;
                state_n    = |bus.notes_to_play ? OPEN : IDLE;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            expected          <= '0;
            cnt               <= '0;
            strum_d           <= 1'b0;
            bus.correct_notes <= '0;
            bus.hit           <= 1'b0;
            bus.miss          <= 1'b0;
        end else begin
            state             <= state_n;
            expected          <= expected_n;
            cnt               <= cnt_n;
            strum_d           <= bus.strum;
            bus.correct_notes <= correct_n;
            bus.hit           <= hit_n;
            bus.miss          <= miss_n;
        end
    end
    score_accumulator #(
        .SCORE_W        (SCORE_W),
        .STREAK_W       (STREAK_W),
        .POINTS_PER_NOTE(POINTS_PER_NOTE)
    ) u_score (
        .clk         (clk),
        .reset       (reset),
        .add_hit     (hit_n),
        .clear_streak(miss_n),
        .score       (bus.score),
        .streak      (bus.streak),
        .multiplier  (bus.multiplier)
    );
endmodule
